// File: rtl/alt_vipcts131_common_fifo_reader.sv
// alt_vipcts131_common_fifo_reader
// Turns the read port of a non-showahead FIFO (data valid one clock after
// fifo_rdreq) into a ready/valid stream through a 2-entry skid buffer.
// Read requests are issued only while the buffer has room for the word that
// will arrive one clock later, so nothing is ever dropped or overwritten.
//
// Optional feature: define ALT_VIPCTS131_FIFO_READER_COUNT_EN to build a
// 32-bit wrapping counter of accepted output beats on beat_count; otherwise
// beat_count is tied to zero and no counter flops exist.
module alt_vipcts131_common_fifo_reader #(
  parameter int DATA_WIDTH = 20
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fifo_rdempty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_rdreq,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [1:0]            level,
  output logic [31:0]           beat_count
);

  // Buffer state: two entries addressed by 1-bit head/tail pointers.
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_level;
  // Set in the cycle after a read request: fifo_q carries that word now.
  logic                  r_inflight;
  // Low during reset and for the first clock after release, so the FIFO
  // (reset by the same event) is never read before it has settled.
  logic                  r_started;

  logic       w_pop;
  logic [2:0] w_credit;
  logic [2:0] w_credit_after;
  logic [1:0] w_level_next;

  assign dout_valid = (r_level != 2'd0);
  assign dout_data  = r_buf[r_head];
  assign level      = r_level;
  assign w_pop      = dout_valid & dout_ready;

  // Credit and read-request decision; a pop this cycle frees a slot, so
  // dout_ready reaches fifo_rdreq combinationally to keep one beat per clock.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    w_credit       = {1'b0, r_level} + {2'b0, r_inflight};
    w_credit_after = w_credit - {2'b0, w_pop};
    fifo_rdreq     = r_started & ~fifo_rdempty & (w_credit_after < 3'd2);
    w_level_next   = 2'(r_level + {1'b0, r_inflight} - {1'b0, w_pop});
  end

  // Buffer write on arrival of the in-flight word, head advance on pop,
  // and level update (simultaneous write and pop leaves level unchanged).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the buffer is only two words and dout_data must read as zero
      // out of reset, so its storage is reset along with the control state.
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_level    <= 2'd0;
      r_inflight <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the
      // pre-edge values of the others, independent of statement order.
      r_started  <= 1'b1;
      r_inflight <= fifo_rdreq;
      r_level    <= w_level_next;
      if (r_inflight) begin
        r_buf[r_tail] <= fifo_q;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

`ifdef ALT_VIPCTS131_FIFO_READER_COUNT_EN
  logic [31:0] r_beat_count;

  // Accepted-beat counter, wraps naturally from all-ones to zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_count <= 32'd0;
    end else if (w_pop) begin
      r_beat_count <= r_beat_count + 32'd1;
    end
  end

  assign beat_count = r_beat_count;
`else
  assign beat_count = 32'd0;
`endif

endmodule

// File: tb/tb_alt_vipcts131_common_fifo_reader.sv
// Bench for alt_vipcts131_common_fifo_reader: a queue-based non-showahead
// FIFO model drives the read port; directed cycle tables cover streaming and
// back-pressure fill, followed by hand-written reset, random-traffic and
// beat-counter sequences.
module tb_alt_vipcts131_common_fifo_reader;

  localparam int DW = 20;

  logic          clock;
  logic          reset_n;
  logic          fifo_rdempty;
  logic [DW-1:0] fifo_q;
  logic          fifo_rdreq;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready;
  logic [1:0]    level;
  logic [31:0]   beat_count;

  alt_vipcts131_common_fifo_reader #(.DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fifo_rdempty (fifo_rdempty),
    .fifo_q       (fifo_q),
    .fifo_rdreq   (fifo_rdreq),
    .dout_data    (dout_data),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .level        (level),
    .beat_count   (beat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [DW-1:0] fifo_mem [$];
  bit            tb_inflight;

  typedef struct {
    bit          restart;
    int          base;
    int          n;
    bit          ready;
    bit          exp_rdreq;
    bit          exp_valid;
    logic [DW-1:0] exp_data;
    logic [1:0]  exp_level;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return DW'(i * 13 + 32'h5A5);
  endfunction

  // One clock: the FIFO model answers a read request seen at this edge by
  // presenting the next word on fifo_q shortly after the edge.
  task automatic tick();
    bit rd;
    rd = fifo_rdreq;
    @(posedge clock);
    #1;
    if (rd && fifo_mem.size() != 0) fifo_q = fifo_mem.pop_front();
    tb_inflight = rd;
    @(negedge clock);
    fifo_rdempty = (fifo_mem.size() == 0);
  endtask

  // Reset DUT and FIFO model together, preload n words base, base+1, ...
  // and release reset at a falling edge; that half-cycle is cycle 0.
  task automatic restart(input int base, input int n);
    reset_n      = 1'b0;
    dout_ready   = 1'b0;
    fifo_rdempty = 1'b1;
    fifo_q       = '0;
    fifo_mem.delete();
    tb_inflight  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int k = 0; k < n; k++) fifo_mem.push_back(DW'(base + k));
    fifo_rdempty = (fifo_mem.size() == 0);
    reset_n      = 1'b1;
  endtask

  initial begin
    int pushed, received, cycles, data_errs, empty_errs, occ_errs;

    //            rst base   n  rdy rdreq vld data      lvl
    // FIFO preloaded 1..5, sink always ready: streaming without bubbles.
    vecs[0]  = '{1, 32'h1,  5, 1, 0, 0, 20'h0,     2'd0};
    vecs[1]  = '{0, 0,      0, 1, 1, 0, 20'h0,     2'd0};
    vecs[2]  = '{0, 0,      0, 1, 1, 0, 20'h0,     2'd0};
    vecs[3]  = '{0, 0,      0, 1, 1, 1, 20'h1,     2'd1};
    vecs[4]  = '{0, 0,      0, 1, 1, 1, 20'h2,     2'd1};
    vecs[5]  = '{0, 0,      0, 1, 1, 1, 20'h3,     2'd1};
    vecs[6]  = '{0, 0,      0, 1, 0, 1, 20'h4,     2'd1};
    vecs[7]  = '{0, 0,      0, 1, 0, 1, 20'h5,     2'd1};
    vecs[8]  = '{0, 0,      0, 1, 0, 0, 20'h0,     2'd0};
    // Four words, sink stalled: fill to 2, stop reading, then drain.
    vecs[9]  = '{1, 32'hA1, 4, 0, 0, 0, 20'h0,     2'd0};
    vecs[10] = '{0, 0,      0, 0, 1, 0, 20'h0,     2'd0};
    vecs[11] = '{0, 0,      0, 0, 1, 0, 20'h0,     2'd0};
    vecs[12] = '{0, 0,      0, 0, 0, 1, 20'hA1,    2'd1};
    vecs[13] = '{0, 0,      0, 0, 0, 1, 20'hA1,    2'd2};
    vecs[14] = '{0, 0,      0, 0, 0, 1, 20'hA1,    2'd2};
    vecs[15] = '{0, 0,      0, 0, 0, 1, 20'hA1,    2'd2};
    vecs[16] = '{0, 0,      0, 1, 1, 1, 20'hA1,    2'd2};
    vecs[17] = '{0, 0,      0, 1, 1, 1, 20'hA2,    2'd1};
    vecs[18] = '{0, 0,      0, 1, 0, 1, 20'hA3,    2'd1};
    vecs[19] = '{0, 0,      0, 1, 0, 1, 20'hA4,    2'd1};
    vecs[20] = '{0, 0,      0, 1, 0, 0, 20'h0,     2'd0};

    // Reset state.
    reset_n      = 1'b0;
    dout_ready   = 1'b1;
    fifo_rdempty = 1'b0;
    fifo_q       = '0;
    tb_inflight  = 1'b0;
    #1;
    check("reset_rdreq", 32'(fifo_rdreq), 32'd0);
    check("reset_valid", 32'(dout_valid), 32'd0);
    check("reset_level", 32'(level),      32'd0);
    check("reset_data",  32'(dout_data),  32'd0);
    check("reset_beats", beat_count,      32'd0);

    // Directed cycle tables.
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].restart) restart(vecs[i].base, vecs[i].n);
      dout_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_rdreq", i), 32'(fifo_rdreq), 32'(vecs[i].exp_rdreq));
      check($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_level", i), 32'(level),      32'(vecs[i].exp_level));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), 32'(dout_data), 32'(vecs[i].exp_data));
      tick();
    end

    // Reset pulse while full: outputs clear at once, no read the cycle after.
    restart(32'h300, 4);
    dout_ready = 1'b0;
    repeat (5) tick();
    #1;
    check("full_before_reset_level", 32'(level), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(dout_valid), 32'd0);
    check("midreset_level", 32'(level),      32'd0);
    check("midreset_data",  32'(dout_data),  32'd0);
    check("midreset_rdreq", 32'(fifo_rdreq), 32'd0);
    @(negedge clock);
    fifo_mem.delete();
    fifo_mem.push_back(20'h311);
    fifo_mem.push_back(20'h312);
    fifo_q       = '0;
    fifo_rdempty = 1'b0;
    tb_inflight  = 1'b0;
    reset_n      = 1'b1;
    #1;
    check("postreset_c0_rdreq", 32'(fifo_rdreq), 32'd0);
    tick();
    #1;
    check("postreset_c1_rdreq", 32'(fifo_rdreq), 32'd1);

    // Random traffic: 10000 words, random producer gaps, random empty flag
    // and 50% sink readiness.
    restart(0, 0);
    pushed = 0; received = 0; cycles = 0;
    data_errs = 0; empty_errs = 0; occ_errs = 0;
    while (received < 10000 && cycles < 60000) begin
      if (pushed < 10000 && $urandom_range(0, 3) != 0) begin
        fifo_mem.push_back(word_of(pushed));
        pushed++;
      end
      fifo_rdempty = (fifo_mem.size() == 0) || ($urandom_range(0, 7) == 0);
      dout_ready   = 1'($urandom_range(0, 1));
      #1;
      if (fifo_rdreq && fifo_rdempty) empty_errs++;
      if (int'(level) + int'(tb_inflight) > 2) occ_errs++;
      if (dout_valid && dout_ready) begin
        if (dout_data !== word_of(received)) data_errs++;
        received++;
      end
      cycles++;
      tick();
    end
    check("random_words_received", received,   32'd10000);
    check("random_data_errors",    data_errs,  32'd0);
    check("random_rdreq_on_empty", empty_errs, 32'd0);
    check("random_occupancy_over", occ_errs,   32'd0);
`ifdef ALT_VIPCTS131_FIFO_READER_COUNT_EN
    check("random_beat_count", beat_count, 32'(received));

    // Counter wrap: preset just below all-ones, then three pops.
    restart(32'h10, 3);
    force dut.r_beat_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_beat_count;
    dout_ready = 1'b1;
    received = 0;
    cycles   = 0;
    while (received < 3 && cycles < 20) begin
      #1;
      if (dout_valid && dout_ready) received++;
      cycles++;
      tick();
    end
    #1;
    check("wrap_pops",       received,   32'd3);
    check("wrap_beat_count", beat_count, 32'h0000_0001);
`else
    check("random_beat_count_off", beat_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
